// File: rtl/uart_tx_sched_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states, the WAIT_BUSY
// guard length and the round-robin pointer wrap helper.
package uart_tx_sched_pkg;

    localparam int IDX_W        = 3;
    localparam int GUARD_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARB       = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    // Next requester after idx, wrapping at n.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        logic [IDX_W:0] s;
        s = {1'b0, idx} + 4'd1;
        return (s >= 4'(n)) ? '0 : s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/UART-side bundle of the transmit scheduler; the scheduler is the
// slave, the requesters plus uart_tx together form the master side.
interface uart_tx_sched_if #(parameter int NREQ = 2);
    import uart_tx_sched_pkg::*;

    logic [NREQ-1:0]   REQ;
    logic [8*NREQ-1:0] REQ_DATA;
    logic [NREQ-1:0]   REQ_LAST;
    logic [NREQ-1:0]   GNT;
    logic [7:0]        TX_DATA;
    logic              TX_GO;
    logic              TX_DONE;
    logic              BUSY;
    logic [IDX_W-1:0]  OWNER;
    logic              LOCKED;

    modport slave (
        input  REQ, REQ_DATA, REQ_LAST, TX_DONE,
        output GNT, TX_DATA, TX_GO, BUSY, OWNER, LOCKED
    );

    modport master (
        output REQ, REQ_DATA, REQ_LAST, TX_DONE,
        input  GNT, TX_DATA, TX_GO, BUSY, OWNER, LOCKED
    );

endinterface

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, cyclic.
// Kept standalone so other shared-peripheral arbiters can reuse it.
module rr_pick
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0] rot;
    logic [IDX_W:0]  s;

    // rot[k] is requester (ptr+k) mod NREQ
    assign rot = NREQ'({req, req} >> ptr);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        s     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                s     = 4'(ptr) + 4'(k);
                if (s >= 4'(NREQ))
                    s = s - 4'(NREQ);
                idx = s[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte requesters,
// with optional packet lock so multi-byte messages are not interleaved.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic           CLK,
    input  logic           RSTb,
    uart_tx_sched_if.slave bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [7:0]       data_q, data_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             go_q, go_d;
    logic             busy_q;
    logic [2:0]       guard_q, guard_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    logic             take;
    logic             owner_req;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.REQ),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = |(bus.REQ & (NREQ'(1) << owner_q));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        data_d   = data_q;
        gnt_d    = '0;
        go_d     = 1'b0;
        guard_d  = guard_q;
        sel      = owner_q;
        take     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                guard_d = '0;
                if (bus.TX_DONE && ((|bus.REQ) || locked_q))
                    state_d = ST_ARB;
            end
            ST_ARB: begin
                // A held lock is only ever released by the owner's LAST byte.
                if (locked_q) begin
                    if (owner_req) begin
                        take = 1'b1;
                        sel  = owner_q;
                    end
                end else if (pick_valid) begin
                    take = 1'b1;
                    sel  = pick_idx;
                end else begin
                    state_d = ST_IDLE;
                end
                if (take) begin
                    data_d   = 8'(bus.REQ_DATA >> {sel, 3'b000});
                    gnt_d    = NREQ'(1) << sel;
                    owner_d  = sel;
                    ptr_d    = wrap_inc(sel, NREQ);
                    locked_d = LOCK_EN && !(|(bus.REQ_LAST & (NREQ'(1) << sel)));
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                go_d    = 1'b1;
                guard_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Guard against a UART that never reports busy.
                if (!bus.TX_DONE || guard_q == 3'(GUARD_CYCLES - 1))
                    state_d = ST_WAIT_DONE;
                else
                    guard_d = guard_q + 3'd1;
            end
            ST_WAIT_DONE: begin
                if (bus.TX_DONE)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            data_q   <= '0;
            gnt_q    <= '0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            guard_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            go_q     <= go_d;
            busy_q   <= (state_d != ST_IDLE);
            guard_q  <= guard_d;
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.TX_DATA = data_q;
    assign bus.TX_GO   = go_q;
    assign bus.BUSY    = busy_q;
    assign bus.OWNER   = owner_q;
    assign bus.LOCKED  = locked_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a locking and a non-locking instance driven from byte
// queues, with a 10-cycle UART model and a queue-level arbitration reference.
module tb_uart_tx_sched;

    localparam int N        = 2;
    localparam int QMAX     = 64;
    localparam int EMAX     = 256;
    localparam int UART_CYC = 10;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;

    uart_tx_sched_if #(.NREQ(N)) bif_lk ();
    uart_tx_sched_if #(.NREQ(N)) bif_nl ();

    uart_tx_sched #(.NREQ(N), .LOCK_EN(1'b1)) u_lk (.CLK(CLK), .RSTb(RSTb), .bus(bif_lk));
    uart_tx_sched #(.NREQ(N), .LOCK_EN(1'b0)) u_nl (.CLK(CLK), .RSTb(RSTb), .bus(bif_nl));

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] qd [2][N][QMAX];
    logic       ql [2][N][QMAX];
    int         qh [2][N];
    int         qn [2][N];
    int         gap[2][N];

    int         exp_idx [2][EMAX];
    logic [7:0] exp_data[2][EMAX];
    logic       exp_lock[2][EMAX];
    int         exp_n[2];
    int         obs_n[2];

    logic       pend[2];
    logic [7:0] pend_data[2];
    int         umode[2];   // 0 normal, 1 stuck idle, 2 held busy
    int         ucnt[2];
    logic       td[2];
    int         gnt_cyc[2], go_cyc[2], fall_cyc[2];
    logic       busy_prev[2];
    int         gap_gnt;
    logic       gap_arm;

    logic [N-1:0]   s_gnt[2];
    logic           s_go[2];
    logic [7:0]     s_dat[2];
    logic           s_busy[2];
    logic [2:0]     s_own[2];
    logic           s_lk[2];
    logic [N-1:0]   d_req[2], d_last[2];
    logic [8*N-1:0] d_data[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic sample();
        s_gnt[0] = bif_lk.GNT;  s_go[0] = bif_lk.TX_GO;  s_dat[0] = bif_lk.TX_DATA;
        s_busy[0] = bif_lk.BUSY; s_own[0] = bif_lk.OWNER; s_lk[0] = bif_lk.LOCKED;
        s_gnt[1] = bif_nl.GNT;  s_go[1] = bif_nl.TX_GO;  s_dat[1] = bif_nl.TX_DATA;
        s_busy[1] = bif_nl.BUSY; s_own[1] = bif_nl.OWNER; s_lk[1] = bif_nl.LOCKED;
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            d_req[d] = '0; d_last[d] = '0; d_data[d] = '0;
            for (int i = 0; i < N; i++) begin
                if (qh[d][i] < qn[d][i] && gap[d][i] == 0) begin
                    d_req[d][i]        = 1'b1;
                    d_last[d][i]       = ql[d][i][qh[d][i]];
                    d_data[d][8*i +: 8] = qd[d][i][qh[d][i]];
                end
            end
        end
        bif_lk.REQ = d_req[0]; bif_lk.REQ_DATA = d_data[0]; bif_lk.REQ_LAST = d_last[0]; bif_lk.TX_DONE = td[0];
        bif_nl.REQ = d_req[1]; bif_nl.REQ_DATA = d_data[1]; bif_nl.REQ_LAST = d_last[1]; bif_nl.TX_DONE = td[1];
    endtask

    task automatic push(input int d, input int i, input logic [7:0] b, input logic last);
        qd[d][i][qn[d][i]] = b;
        ql[d][i][qn[d][i]] = last;
        qn[d][i]++;
    endtask

    // Expected grant order from the queued bytes: a held lock serves the owner,
    // otherwise the first non-empty queue at or after the pointer.
    task automatic build_model(input int d, input bit lk);
        int  h[N];
        int  ptr = 0;
        int  owner = 0;
        int  sel;
        bit  locked = 0;
        exp_n[d] = 0;
        for (int i = 0; i < N; i++) h[i] = qh[d][i];
        for (int n = 0; n < EMAX; n++) begin
            sel = -1;
            if (locked) begin
                if (h[owner] < qn[d][owner]) sel = owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (sel < 0 && h[(ptr + k) % N] < qn[d][(ptr + k) % N]) sel = (ptr + k) % N;
            end
            if (sel < 0) break;
            exp_idx[d][exp_n[d]]  = sel;
            exp_data[d][exp_n[d]] = qd[d][sel][h[sel]];
            exp_lock[d][exp_n[d]] = lk && !ql[d][sel][h[sel]];
            exp_n[d]++;
            locked = lk && !ql[d][sel][h[sel]];
            h[sel]++;
            owner = sel;
            ptr   = (sel + 1) % N;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        sample();
        for (int d = 0; d < 2; d++) begin
            if (s_gnt[d] != '0) begin
                int k  = obs_n[d];
                int gi = 0;
                for (int i = N - 1; i >= 0; i--) if (s_gnt[d][i]) gi = i;
                chk("gnt_go_overlap", 32'(s_go[d]), 0);
                chk("gnt_without_go", 32'(pend[d]), 0);
                if (k < exp_n[d]) begin
                    chk("gnt_vec", 32'(s_gnt[d]), 32'(1) << exp_idx[d][k]);
                    chk("owner", 32'(s_own[d]), 32'(exp_idx[d][k]));
                    chk("locked", 32'(s_lk[d]), 32'(exp_lock[d][k]));
                    pend_data[d] = exp_data[d][k];
                end else begin
                    chk("extra_gnt", k, exp_n[d]);
                end
                if (k == 0) gnt_cyc[d] = cyc;
                if (d == 0 && gap[0][0] > 0) gap_gnt++;
                if (gap_arm && d == 0 && gi == 0) begin
                    gap[0][0] = 20;
                    gap_arm   = 1'b0;
                end
                obs_n[d]++;
                pend[d] = 1'b1;
                if (qh[d][gi] < qn[d][gi]) qh[d][gi]++;
            end
            if (s_go[d]) begin
                chk("go_after_gnt", 32'(pend[d]), 1);
                chk("tx_data", 32'(s_dat[d]), 32'(pend_data[d]));
                pend[d]   = 1'b0;
                go_cyc[d] = cyc;
                if (umode[d] == 0) begin
                    td[d]   = 1'b0;
                    ucnt[d] = UART_CYC;
                end
            end else if (ucnt[d] > 0) begin
                ucnt[d]--;
                if (ucnt[d] == 0) td[d] = 1'b1;
            end
            if (umode[d] == 1) td[d] = 1'b1;
            if (umode[d] == 2) td[d] = 1'b0;
            if (busy_prev[d] && !s_busy[d]) fall_cyc[d] = cyc;
            busy_prev[d] = s_busy[d];
        end
        if (gap[0][0] == 3) begin
            chk("gap_busy", 32'(s_busy[0]), 1);
            chk("gap_locked", 32'(s_lk[0]), 1);
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++)
                if (gap[d][i] > 0) gap[d][i]--;
        drive();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        bit done = 0;
        while (!done && n < maxc) begin
            step();
            n++;
            done = 1;
            for (int d = 0; d < 2; d++)
                if (obs_n[d] < exp_n[d] || pend[d] || ucnt[d] != 0 || s_busy[d]) done = 0;
        end
        chk("drain_timeout", 32'(done), 1);
        repeat (2) step();
        chk("busy_idle_lk", 32'(s_busy[0]), 0);
        chk("busy_idle_nl", 32'(s_busy[1]), 0);
    endtask

    // Asserts reset off the clock edge and checks outputs clear before the next edge.
    task automatic do_reset(input int mode);
        @(negedge CLK);
        #2;
        RSTb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin qh[d][i] = 0; qn[d][i] = 0; gap[d][i] = 0; end
            obs_n[d] = 0; exp_n[d] = 0; pend[d] = 1'b0; ucnt[d] = 0;
            umode[d] = mode; td[d] = (mode != 2); busy_prev[d] = 1'b0;
        end
        gap_arm = 1'b0;
        gap_gnt = 0;
        drive();
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", 32'(s_gnt[d]), 0);
            chk("rst_go", 32'(s_go[d]), 0);
            chk("rst_data", 32'(s_dat[d]), 0);
            chk("rst_owner", 32'(s_own[d]), 0);
            chk("rst_locked", 32'(s_lk[d]), 0);
            chk("rst_busy", 32'(s_busy[d]), 0);
        end
        repeat (2) step();
        RSTb = 1'b1;
    endtask

    initial begin
        int c0;
        int n;
        bit seen;

        // Single byte on an idle UART: latency and busy release
        do_reset(0);
        push(0, 0, 8'h41, 1'b1);
        build_model(0, 1'b1); build_model(1, 1'b0);
        c0 = cyc;
        drive();
        drain(200);
        chk("single_gnt_lat", gnt_cyc[0] - c0, 2);
        chk("single_go_lat", go_cyc[0] - c0, 3);
        chk("single_busy_fall", fall_cyc[0] - go_cyc[0], UART_CYC + 1);

        // Contention with REQ=11 held
        do_reset(0);
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 3; b++) begin
                push(d, 0, 8'hA0, 1'b1);
                push(d, 1, 8'hB0, 1'b1);
            end
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        drain(400);

        // Packet 10,11,12 from req0 while req1 keeps requesting
        do_reset(0);
        for (int d = 0; d < 2; d++) begin
            push(d, 0, 8'h10, 1'b0); push(d, 0, 8'h11, 1'b0); push(d, 0, 8'h12, 1'b1);
            push(d, 1, 8'h20, 1'b1); push(d, 1, 8'h21, 1'b1); push(d, 1, 8'h22, 1'b1);
        end
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        drain(400);

        // Same packet, owner drops REQ for 20 cycles after its first byte
        do_reset(0);
        for (int d = 0; d < 2; d++) begin
            push(d, 0, 8'h10, 1'b0); push(d, 0, 8'h11, 1'b0); push(d, 0, 8'h12, 1'b1);
            push(d, 1, 8'h20, 1'b1); push(d, 1, 8'h21, 1'b1);
        end
        build_model(0, 1'b1); build_model(1, 1'b0);
        gap_arm = 1'b1;
        drive();
        drain(500);
        chk("gap_no_grant", gap_gnt, 0);

        // UART busy out of reset: no grant until TX_DONE rises
        do_reset(2);
        push(0, 1, 8'h55, 1'b1);
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        repeat (15) step();
        chk("busy_start_nogrant", obs_n[0], 0);
        umode[0] = 0;
        td[0]    = 1'b1;
        drive();
        drain(200);

        // UART never reports busy: guard leaves WAIT_BUSY after 4 cycles
        do_reset(1);
        push(0, 0, 8'h77, 1'b1);
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        drain(200);
        chk("guard_exit", fall_cyc[0] - go_cyc[0], 5);

        // Random packets on both instances
        for (int r = 0; r < 3; r++) begin
            do_reset(0);
            for (int i = 0; i < N; i++) begin
                int npk = int'($urandom_range(1, 3));
                for (int p = 0; p < npk; p++) begin
                    int len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) begin
                        logic [7:0] v = 8'($urandom);
                        push(0, i, v, b == len - 1);
                        push(1, i, v, b == len - 1);
                    end
                end
            end
            build_model(0, 1'b1); build_model(1, 1'b0);
            drive();
            drain(3000);
        end

        // Reset in WAIT_DONE with the lock held; pointer must restart at 0
        do_reset(0);
        push(0, 0, 8'h10, 1'b0); push(0, 0, 8'h11, 1'b0); push(0, 0, 8'h12, 1'b1);
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        n = 0;
        seen = 0;
        while (!seen && n < 30) begin
            step();
            n++;
            if (obs_n[0] == 1 && !pend[0]) seen = 1;
        end
        chk("mid_go_seen", 32'(seen), 1);
        repeat (3) step();
        chk("pre_rst_locked", 32'(s_lk[0]), 1);
        chk("pre_rst_busy", 32'(s_busy[0]), 1);
        do_reset(0);
        push(0, 0, 8'h30, 1'b1); push(0, 1, 8'h31, 1'b1);
        build_model(0, 1'b1); build_model(1, 1'b0);
        drive();
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
